mlp_layer_sequencer: RTL and testbench



---
 rtl/mlp_layer_sequencer.sv | 109 ++++++++++
 tb/tb_mlp_layer_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_sequencer
// Purpose  : Steps one dot-product unit through every neuron of a fully
//            connected layer and collects the (optionally ReLU'd) results.
//            Optional feature macro: MLP_RELU_EN (clamp negatives to zero).
// Revision : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
    parameter int  NEURONS        = 10,
    parameter int  DATA_WIDTH     = 16,
    parameter int  FRACTION_WIDTH = 8,
    localparam int IDX_W          = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] dot_result_in,
    input  logic                         dot_finished_in,
    output logic                         dot_run_out,
    output logic        [IDX_W-1:0]      neuron_idx_out,
    output logic signed [DATA_WIDTH-1:0] layer_out [NEURONS],
    output logic                         busy_out,
    output logic                         done_out
);

    if (NEURONS < 1 || FRACTION_WIDTH >= DATA_WIDTH) begin : g_param_check
        $error("mlp_layer_sequencer: illegal NEURONS / FRACTION_WIDTH setting");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    state_t                         state_q, state_d;
    logic        [IDX_W-1:0]        idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   layer_q [NEURONS];
    logic                           capture;
    logic signed [DATA_WIDTH-1:0]   act_value;

`ifdef MLP_RELU_EN
    assign act_value = dot_result_in[DATA_WIDTH-1] ? '0 : dot_result_in;
`else
    assign act_value = dot_result_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (dot_finished_in) begin
                    capture = 1'b1;
                    // Index advances on the capture edge so the upstream
                    // weight/bias mux settles during GAP.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = GAP;
                    end
                end
            end
            GAP:     state_d = RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NEURONS; k++) begin : g_layer
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                layer_q[k] <= '0;
            end else if (capture && (idx_q == IDX_W'(k))) begin
                layer_q[k] <= act_value;
            end
        end
    end

    assign layer_out      = layer_q;
    assign neuron_idx_out = idx_q;
    assign dot_run_out    = (state_q == RUN);
    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_layer_sequencer
// Purpose  : Self-checking bench: vector table, random passes against a
//            cycle-arithmetic layer model, and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

`ifdef MLP_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic clk;
    logic reset_n;

    // Three-neuron instance and its dot-unit model
    logic               start3, fin3, run3, busy3, done3;
    logic        [1:0]  idx3;
    logic signed [15:0] dres3;
    logic signed [15:0] lay3 [3];
    logic signed [15:0] res3 [4];
    int                 s3;
    int                 cnt3;

    // Single-neuron instance and its dot-unit model
    logic               start1, fin1, run1, busy1, done1;
    logic        [0:0]  idx1;
    logic signed [15:0] lay1 [1];
    logic signed [15:0] res1;
    int                 s1;
    int                 cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_layer [3];

    typedef struct {
        int s;
        int r0, r1, r2;
        int na, nb;
        int done_c;
        int w0, w1, w2;
        int z0, z1, z2;
    } vec_t;
    vec_t vecs [4];

    mlp_layer_sequencer #(.NEURONS(3), .DATA_WIDTH(16), .FRACTION_WIDTH(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start3),
        .dot_result_in   (dres3),
        .dot_finished_in (fin3),
        .dot_run_out     (run3),
        .neuron_idx_out  (idx3),
        .layer_out       (lay3),
        .busy_out        (busy3),
        .done_out        (done3)
    );

    mlp_layer_sequencer #(.NEURONS(1), .DATA_WIDTH(16), .FRACTION_WIDTH(8)) dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start1),
        .dot_result_in   (res1),
        .dot_finished_in (fin1),
        .dot_run_out     (run1),
        .neuron_idx_out  (idx1),
        .layer_out       (lay1),
        .busy_out        (busy1),
        .done_out        (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dot units: counter cleared while run is low, finished when it reaches S
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cnt3 <= 0;
        else if (!run3)      cnt3 <= 0;
        else if (cnt3 < s3)  cnt3 <= cnt3 + 1;
    end
    assign fin3  = (cnt3 == s3);
    assign dres3 = res3[idx3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cnt1 <= 0;
        else if (!run1)      cnt1 <= 0;
        else if (cnt1 < s1)  cnt1 <= cnt1 + 1;
    end
    assign fin1 = (cnt1 == s1);

    function automatic int act(input int v);
        return (RELU_ON && v < 0) ? 0 : v;
    endfunction

    task automatic chk(input string nm, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, actual, expected);
        end
    endtask

    // Caller has already set start3=1; one layer pass is checked cycle by cycle.
    task automatic run_pass(input int S, input int r0, input int r1, input int r2,
                            input int na, input int nb, input bit chain,
                            output int done_cyc, output int done_cnt);
        int T, total, e_idx, e_lay;
        int nv [3];
        T     = S + 2;
        total = 3 * T;
        s3    = S;
        res3[0] = 16'(r0); res3[1] = 16'(r1); res3[2] = 16'(r2); res3[3] = 16'sd0;
        nv[0] = act(r0); nv[1] = act(r1); nv[2] = act(r2);
        done_cyc = -1;
        done_cnt = 0;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            e_idx = (c / T > 2) ? 2 : c / T;
            chk($sformatf("run c=%0d", c),  int'(run3),  int'((c < total) && (c % T != 0)));
            chk($sformatf("busy c=%0d", c), int'(busy3), int'(c <= total));
            chk($sformatf("done c=%0d", c), int'(done3), int'(c == total));
            chk($sformatf("idx c=%0d", c),  int'(idx3),  e_idx);
            for (int k = 0; k < 3; k++) begin
                e_lay = (c >= (k + 1) * T) ? nv[k] : exp_layer[k];
                chk($sformatf("layer[%0d] c=%0d", k, c), int'(lay3[k]), e_lay);
            end
            if (done3) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start3 = ((c == na) || (c == nb) || (chain && c == total + 1)) ? 1'b1 : 1'b0;
        end
        for (int k = 0; k < 3; k++) exp_layer[k] = nv[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dn, r0, r1, r2, S, na, nb;
        vecs[0] = '{4, 5, 12, 7,          3, 10, 18, 5, 12, 7,          5, 12, 7};
        vecs[1] = '{4, -3, 4, -128,       0, 0,  18, -3, 4, -128,       0, 4, 0};
        vecs[2] = '{1, 100, -1, 32767,    2, 0,  9,  100, -1, 32767,    100, 0, 32767};
        vecs[3] = '{6, -32768, 0, 1,      0, 23, 24, -32768, 0, 1,      0, 0, 1};

        reset_n = 1'b0;
        start3  = 1'b0;
        start1  = 1'b0;
        s3 = 4; s1 = 1;
        res1 = 16'sd0;
        for (int k = 0; k < 4; k++) res3[k] = 16'sd0;
        for (int k = 0; k < 3; k++) exp_layer[k] = 0;
        repeat (2) @(negedge clk);

        chk("reset run",   int'(run3),  0);
        chk("reset busy",  int'(busy3), 0);
        chk("reset done",  int'(done3), 0);
        chk("reset idx",   int'(idx3),  0);
        for (int k = 0; k < 3; k++) chk($sformatf("reset layer[%0d]", k), int'(lay3[k]), 0);
        chk("reset busy1", int'(busy1), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single neuron: done in cycle 3, run never drops before DONE
        res1   = -16'sd77;
        start1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("n1 done c=%0d", c),  int'(done1), int'(c == 3));
            chk($sformatf("n1 run c=%0d", c),   int'(run1),  int'(c <= 2));
            chk($sformatf("n1 busy c=%0d", c),  int'(busy1), int'(c <= 3));
            chk($sformatf("n1 idx c=%0d", c),   int'(idx1),  0);
            chk($sformatf("n1 layer c=%0d", c), int'(lay1[0]), (c >= 3) ? act(-77) : 0);
        end

        // Vector table
        for (int v = 0; v < 4; v++) begin
            start3 = 1'b1;
            run_pass(vecs[v].s, vecs[v].r0, vecs[v].r1, vecs[v].r2,
                     vecs[v].na, vecs[v].nb, 1'b0, dc, dn);
            chk($sformatf("vec%0d done cycle", v), dc, vecs[v].done_c);
            chk($sformatf("vec%0d done pulses", v), dn, 1);
            chk($sformatf("vec%0d out0", v), int'(lay3[0]), RELU_ON ? vecs[v].z0 : vecs[v].w0);
            chk($sformatf("vec%0d out1", v), int'(lay3[1]), RELU_ON ? vecs[v].z1 : vecs[v].w1);
            chk($sformatf("vec%0d out2", v), int'(lay3[2]), RELU_ON ? vecs[v].z2 : vecs[v].w2);
            @(negedge clk);
        end

        // Back-to-back: start in the first IDLE cycle after done
        start3 = 1'b1;
        run_pass(2, 1000, -2000, 3000, 0, 0, 1'b1, dc, dn);
        chk("b2b first pulses", dn, 1);
        run_pass(3, -11, 22, -33, 0, 0, 1'b0, dc, dn);
        chk("b2b second done cycle", dc, 15);
        @(negedge clk);

        // Reset mid-layer in cycle 8
        s3 = 4;
        res3[0] = 16'sd321; res3[1] = -16'sd654; res3[2] = 16'sd987;
        start3 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start3 = 1'b0;
        end
        chk("pre-reset layer0", int'(lay3[0]), 321);
        reset_n = 1'b0;
        #1;
        chk("async run",  int'(run3),  0);
        chk("async busy", int'(busy3), 0);
        chk("async idx",  int'(idx3),  0);
        for (int k = 0; k < 3; k++) chk($sformatf("async layer[%0d]", k), int'(lay3[k]), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("in-reset done %0d", c), int'(done3), 0);
            chk($sformatf("in-reset busy %0d", c), int'(busy3), 0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_layer[k] = 0;
        @(negedge clk);
        start3 = 1'b1;
        run_pass(4, 5, 12, 7, 0, 0, 1'b0, dc, dn);
        chk("post-reset done cycle", dc, 18);
        @(negedge clk);

        // Randomized passes against the model
        for (int p = 0; p < 6; p++) begin
            S  = int'($urandom_range(6, 1));
            r0 = int'($urandom_range(65535, 0)) - 32768;
            r1 = int'($urandom_range(65535, 0)) - 32768;
            r2 = int'($urandom_range(65535, 0)) - 32768;
            na = int'($urandom_range(3 * (S + 2), 1));
            nb = int'($urandom_range(3 * (S + 2), 1));
            start3 = 1'b1;
            run_pass(S, r0, r1, r2, na, nb, 1'b0, dc, dn);
            chk($sformatf("rand%0d done cycle", p), dc, 3 * (S + 2));
            chk($sformatf("rand%0d done pulses", p), dn, 1);
            if (p[0]) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
